// File: rtl/spike_receiver_pkg.sv
// Shared constants for the spike packet link: packet layout and the "no source" marker.
package spike_receiver_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned PKT_W      = 2 * ADDR_W_DEF;

  localparam int unsigned ORIGIN_MSB = 23;
  localparam int unsigned ORIGIN_LSB = 12;
  localparam int unsigned DEST_MSB   = 11;
  localparam int unsigned DEST_LSB   = 0;

  localparam logic [ADDR_W_DEF-1:0] NO_SOURCE = 12'hFFF;

  function automatic logic [ADDR_W_DEF-1:0] pkt_origin(input logic [PKT_W-1:0] pkt);
    return pkt[ORIGIN_MSB:ORIGIN_LSB];
  endfunction

  function automatic logic [ADDR_W_DEF-1:0] pkt_dest(input logic [PKT_W-1:0] pkt);
    return pkt[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Single-clock FIFO with async active-low reset; full/empty come from the registered count.
module spike_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_receiver.sv
// Spike packet receiver: buffers {origin, destination} packets and strobes the addressed neuron.
// Optional out-of-range drop counter enabled by SPIKE_RECEIVER_DROP_COUNT_EN.
module spike_receiver
  import spike_receiver_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                              CLK,
  input  logic                              RESET_N,
  input  logic                              clear,
  input  logic [2*ADDR_W-1:0]               packet_in,
  input  logic                              packet_valid,
  output logic                              packet_ready,
  output logic [NUM_NEURONS*ADDR_W-1:0]     source_addresses,
  output logic [NUM_NEURONS-1:0]            source_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [15:0]                       dropped_count
);

  logic                                   full;
  logic                                   empty;
  logic                                   push;
  logic                                   pop;
  logic [2*ADDR_W-1:0]                    head;
  logic [ADDR_W-1:0]                      idx;
  logic [NUM_NEURONS-1:0]                 hit;
  logic [NUM_NEURONS-1:0][ADDR_W-1:0]     slots;

  assign packet_ready = !full;
  assign push         = packet_valid && packet_ready;
  assign pop          = !empty && !clear;

  spike_fifo #(
    .WIDTH (2 * ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push),
    .pop     (pop),
    .wr_data (packet_in),
    .rd_data (head),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

  assign idx = head[ADDR_W-1:0] - ADDR_W'(BASE_ADDR);

  // One-hot decode; an all-zero result means the destination is out of range.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
      hit[i] = (idx == ADDR_W'(i));
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slots        <= '1;
      source_valid <= '0;
    end else begin
      source_valid <= pop ? hit : '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (pop && hit[i]) slots[i] <= head[2*ADDR_W-1:ADDR_W];
      end
    end
  end

  assign source_addresses = slots;

`ifdef SPIKE_RECEIVER_DROP_COUNT_EN
  logic drop;
  assign drop = pop && (hit == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dropped_count <= '0;
    end else if (drop && (dropped_count != '1)) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
`else
  assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_spike_receiver.sv
// Self-checking bench for spike_receiver: two instances (BASE_ADDR 0 and 16) against a queue-based model.
module tb_spike_receiver;

  localparam int N  = 10;
  localparam int AW = 12;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);
  localparam int BASES [2] = '{0, 16};

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            clear = 1'b0;
  logic            packet_valid = 1'b0;
  logic [2*AW-1:0] packet_in = '0;

  logic [N*AW-1:0] sa0, sa16;
  logic [N-1:0]    sv0, sv16;
  logic [CW-1:0]   fc0, fc16;
  logic            pr0, pr16;
  logic [15:0]     dc0, dc16;

  spike_receiver #(.NUM_NEURONS(N), .ADDR_W(AW), .BASE_ADDR(0), .FIFO_DEPTH(D)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .clear(clear), .packet_in(packet_in),
    .packet_valid(packet_valid), .packet_ready(pr0), .source_addresses(sa0),
    .source_valid(sv0), .fifo_count(fc0), .dropped_count(dc0));

  spike_receiver #(.NUM_NEURONS(N), .ADDR_W(AW), .BASE_ADDR(16), .FIFO_DEPTH(D)) dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .clear(clear), .packet_in(packet_in),
    .packet_valid(packet_valid), .packet_ready(pr16), .source_addresses(sa16),
    .source_valid(sv16), .fifo_count(fc16), .dropped_count(dc16));

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: packet queue plus per-instance slot contents, strobe and drop count.
  logic [2*AW-1:0] mq [$];
  logic [AW-1:0]   m_slot [2][N];
  logic [N-1:0]    m_sv [2];
  int              m_drop [2];

  function automatic void model_reset();
    mq.delete();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < N; i++) m_slot[b][i] = 12'hFFF;
      m_sv[b]   = '0;
      m_drop[b] = 0;
    end
  endfunction

  function automatic void model_step();
    bit do_pop;
    bit do_push;
    logic [2*AW-1:0] p;
    int idx;
    do_pop  = (mq.size() > 0) && !clear;
    do_push = packet_valid && (mq.size() < D);
    for (int b = 0; b < 2; b++) m_sv[b] = '0;
    if (do_pop) begin
      p = mq.pop_front();
      for (int b = 0; b < 2; b++) begin
        idx = (int'(p[AW-1:0]) - BASES[b] + 4096) % 4096;
        if (idx < N) begin
          m_slot[b][idx] = p[2*AW-1:AW];
          m_sv[b] = N'(1) << idx;
        end else if (m_drop[b] < 65535) begin
          m_drop[b]++;
        end
      end
    end
    if (do_push) mq.push_back(packet_in);
  endfunction

  function automatic logic [N*AW-1:0] exp_sa(input int b);
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = m_slot[b][i];
    return r;
  endfunction

  function automatic logic [15:0] exp_drop(input int b);
`ifdef SPIKE_RECEIVER_DROP_COUNT_EN
    return 16'(m_drop[b]);
`else
    return (b < 0) ? 16'hFFFF : 16'd0;
`endif
  endfunction

  task automatic compare_all();
    check("fifo_count0",  128'(fc0),  128'(mq.size()));
    check("fifo_count16", 128'(fc16), 128'(mq.size()));
    check("ready0",  128'(pr0),  128'(mq.size() < D));
    check("ready16", 128'(pr16), 128'(mq.size() < D));
    check("slots0",  128'(sa0),  128'(exp_sa(0)));
    check("slots16", 128'(sa16), 128'(exp_sa(1)));
    check("strobe0",  128'(sv0),  128'(m_sv[0]));
    check("strobe16", 128'(sv16), 128'(m_sv[1]));
    check("dropped0",  128'(dc0),  128'(exp_drop(0)));
    check("dropped16", 128'(dc16), 128'(exp_drop(1)));
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RESET_N) model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [AW-1:0] origin;
    logic [AW-1:0] dest;
    logic [N-1:0]  sv0;
    logic [N-1:0]  sv16;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic ready_pre;

    tbl[0] = '{12'd1, 12'd4,   10'b0000010000, 10'b0000000000};
    tbl[1] = '{12'd3, 12'hFFB, 10'b0000000000, 10'b0000000000};
    tbl[2] = '{12'd9, 12'd0,   10'b0000000001, 10'b0000000000};
    tbl[3] = '{12'd5, 12'd9,   10'b1000000000, 10'b0000000000};
    tbl[4] = '{12'd2, 12'd25,  10'b0000000000, 10'b1000000000};
    tbl[5] = '{12'd2, 12'd26,  10'b0000000000, 10'b0000000000};
    tbl[6] = '{12'd2, 12'd15,  10'b0000000000, 10'b0000000000};
    tbl[7] = '{12'd7, 12'd16,  10'b0000000000, 10'b0000000001};

    model_reset();
    #12;
    compare_all();
    RESET_N = 1'b1;
    cycle();

    // Single packets: strobe appears one edge after acceptance.
    for (int v = 0; v < 8; v++) begin
      packet_in = {tbl[v].origin, tbl[v].dest};
      packet_valid = 1'b1;
      cycle();
      packet_valid = 1'b0;
      cycle();
      check("tbl_strobe0",  128'(sv0),  128'(tbl[v].sv0));
      check("tbl_strobe16", 128'(sv16), 128'(tbl[v].sv16));
      for (int i = 0; i < N; i++) begin
        if (tbl[v].sv0[i])  check("tbl_slot0",  128'(sa0[i*AW +: AW]),  128'(tbl[v].origin));
        if (tbl[v].sv16[i]) check("tbl_slot16", 128'(sa16[i*AW +: AW]), 128'(tbl[v].origin));
      end
      cycle();
    end

    // Back-to-back stream of 9 with valid held.
    for (int k = 0; k < 9; k++) begin
      packet_in = {12'(100 + k), 12'(k)};
      packet_valid = 1'b1;
      check("b2b_ready", 128'(pr0), 128'(1));
      cycle();
    end
    packet_valid = 1'b0;
    repeat (2) cycle();

    // Fill under clear, hold the 9th, then drain.
    clear = 1'b1;
    for (int k = 0; k < 8; k++) begin
      packet_in = {12'(200 + k), 12'(9 - k)};
      packet_valid = 1'b1;
      cycle();
    end
    check("full_count", 128'(fc0), 128'(8));
    check("full_ready", 128'(pr0), 128'(0));
    packet_in = {12'd300, 12'd3};
    repeat (2) cycle();
    check("held_count", 128'(fc0), 128'(8));
    clear = 1'b0;
    repeat (2) cycle();
    packet_valid = 1'b0;
    repeat (10) cycle();

    // clear asserted in the accept cycle.
    clear = 1'b1;
    packet_in = {12'd7, 12'd6};
    packet_valid = 1'b1;
    cycle();
    packet_valid = 1'b0;
    repeat (2) begin
      cycle();
      check("clear_no_strobe", 128'(sv0), 128'(0));
    end
    clear = 1'b0;
    cycle();
    check("clear_release_strobe", 128'(sv0), 128'(10'b0001000000));
    check("clear_release_slot", 128'(sa0[6*AW +: AW]), 128'(12'd7));
    cycle();

    // Reset with five packets buffered.
    clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      packet_in = {12'(50 + k), 12'(k)};
      packet_valid = 1'b1;
      cycle();
    end
    packet_valid = 1'b0;
    check("pre_reset_count", 128'(fc0), 128'(5));
    #2;
    RESET_N = 1'b0;
    model_reset();
    #1;
    check("async_reset_count", 128'(fc0), 128'(0));
    check("async_reset_ready", 128'(pr0), 128'(1));
    check("async_reset_slots", 128'(sa0), 128'({N*AW{1'b1}}));
    compare_all();
    #2;
    RESET_N = 1'b1;
    clear = 1'b0;
    repeat (3) begin
      cycle();
      check("no_stale", 128'(sv0), 128'(0));
    end

    // Randomized traffic; sender holds a packet until accepted.
    packet_in = {12'($urandom), 12'($urandom_range(0, 31))};
    for (int k = 0; k < 400; k++) begin
      clear = ($urandom_range(0, 7) == 0);
      packet_valid = ($urandom_range(0, 3) != 0);
      ready_pre = pr0;
      cycle();
      if (packet_valid && ready_pre) begin
        if ($urandom_range(0, 9) == 0) packet_in = {12'($urandom), 12'($urandom)};
        else packet_in = {12'($urandom), 12'($urandom_range(0, 31))};
      end
    end
    clear = 1'b0;
    packet_valid = 1'b0;
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
